// File: rtl/serial_reduce_if.sv
// Operand stream in, result strobe out, for the serial reduction core.
// The transmitter side uses the master modport and the core uses the slave modport.
interface serial_reduce_if #(
    parameter int DATA_W = 5,
    parameter int NUM_IN = 3
) ();
    localparam int OUT_W = DATA_W + $clog2(NUM_IN);

    logic              in_valid;
    logic [DATA_W-1:0] in;
    logic [1:0]        mode;
    logic              out_valid;
    logic [OUT_W-1:0]  out;
    logic              out_err;

    modport master (
        output in_valid, in, mode,
        input  out_valid, out, out_err
    );

    modport slave (
        input  in_valid, in, mode,
        output out_valid, out, out_err
    );
endinterface

// File: rtl/serial_reduce_core.sv
// Serial frame reducer: takes NUM_IN operands one per cycle and reduces them by sum, max, min or range.
// It emits one result strobe OUT_DELAY cycles after the first idle cycle that follows a frame.
module serial_reduce_core #(
    parameter int DATA_W    = 5,
    parameter int NUM_IN    = 3,
    parameter int OUT_DELAY = 1
) (
    input logic            clk,
    input logic            rst_n,
    serial_reduce_if.slave bus
);
    localparam int OUT_W  = DATA_W + $clog2(NUM_IN);
    localparam int CNT_W  = $clog2(NUM_IN + 2);
    localparam int WAIT_W = $clog2(OUT_DELAY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_OUT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [OUT_W-1:0]   acc_reg;
    logic [DATA_W-1:0]  max_reg, min_reg;
    logic [1:0]         mode_reg;
    logic [WAIT_W-1:0]  wait_reg;
    logic               out_valid_reg, out_err_reg;
    logic [OUT_W-1:0]   out_reg;

    logic               out_valid_next, out_err_next, wait_done;
    logic [OUT_W-1:0]   out_next;

    // WAIT always begins with wait_reg at zero and lasts OUT_DELAY-1 cycles.
    assign wait_done = int'(wait_reg) >= OUT_DELAY - 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.in_valid) state_next = S_ACC;
            S_ACC:  if (!bus.in_valid) state_next = (OUT_DELAY == 1) ? S_OUT : S_WAIT;
            S_WAIT: if (wait_done) state_next = S_OUT;
            S_OUT:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The result is registered on the edge that enters OUT.
    always_comb begin
        out_valid_next = (state_next == S_OUT);
        out_err_next   = (count_reg != CNT_W'(NUM_IN));
        out_next       = '0;
        if (!out_err_next) begin
            case (mode_reg)
                2'd0: out_next = acc_reg;
                2'd1: out_next = OUT_W'(max_reg);
                2'd2: out_next = OUT_W'(min_reg);
                2'd3: out_next = OUT_W'(DATA_W'(max_reg - min_reg));
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            acc_reg       <= '0;
            max_reg       <= '0;
            min_reg       <= '0;
            mode_reg      <= '0;
            wait_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            out_err_reg   <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && bus.in_valid) begin
                acc_reg   <= OUT_W'(bus.in);
                max_reg   <= bus.in;
                min_reg   <= bus.in;
                mode_reg  <= bus.mode;
                count_reg <= CNT_W'(1);
            end else if (state_reg == S_ACC && bus.in_valid) begin
                acc_reg <= acc_reg + OUT_W'(bus.in);
                if (bus.in > max_reg) max_reg <= bus.in;
                if (bus.in < min_reg) min_reg <= bus.in;
                // NUM_IN+1 marks any overrun regardless of how long it runs.
                if (count_reg != CNT_W'(NUM_IN + 1)) count_reg <= count_reg + CNT_W'(1);
            end
            wait_reg      <= (state_reg == S_WAIT) ? wait_reg + WAIT_W'(1) : '0;
            out_valid_reg <= out_valid_next;
            if (out_valid_next) begin
                out_reg     <= out_next;
                out_err_reg <= out_err_next;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;
    assign bus.out_err   = out_err_reg;
endmodule
